operand_fetch: RTL

- Issue-to-execute stage that sits directly downstream of the reservation station, one lane per issue port.
- Owns the physical register file, written from the result buses.
- Per lane: latches the issued uop, reads operands by tag with same-cycle result-bus bypass, and late-captures operands whose producer result had not yet been broadcast.
- Back-pressures the reservation station through per-lane stall signals.

---
 rtl/operand_fetch.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
// Issue-to-execute operand fetch: per-lane uop latch, physical register file,
// result-bus bypass and late capture of operands whose producer has not yet broadcast.
module operand_fetch #(
  parameter int NUM_UOPS         = 2,
  parameter int RESULT_BUS_COUNT = 3,
  parameter int TAG_COUNT        = 64,
  parameter int XLEN             = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         IN_uopValid      [NUM_UOPS],
  input  logic [$clog2(TAG_COUNT)-1:0] IN_tagA          [NUM_UOPS],
  input  logic [$clog2(TAG_COUNT)-1:0] IN_tagB          [NUM_UOPS],
  input  logic                         IN_useImmB       [NUM_UOPS],
  input  logic [XLEN-1:0]              IN_imm           [NUM_UOPS],
  input  logic [$clog2(TAG_COUNT)-1:0] IN_tagDst        [NUM_UOPS],
  input  logic [4:0]                   IN_nmDst         [NUM_UOPS],
  input  logic [5:0]                   IN_sqN           [NUM_UOPS],
  input  logic [1:0]                   IN_fu            [NUM_UOPS],
  input  logic [5:0]                   IN_opcode        [NUM_UOPS],
  input  logic                         IN_stall         [NUM_UOPS],
  input  logic                         IN_resultValid   [RESULT_BUS_COUNT],
  input  logic [$clog2(TAG_COUNT)-1:0] IN_resultTag     [RESULT_BUS_COUNT],
  input  logic [XLEN-1:0]              IN_resultData    [RESULT_BUS_COUNT],
  input  logic                         IN_invalidate,
  input  logic [5:0]                   IN_invalidateSqN,
  output logic                         OUT_stall        [NUM_UOPS],
  output logic                         OUT_valid        [NUM_UOPS],
  output logic [XLEN-1:0]              OUT_srcA         [NUM_UOPS],
  output logic [XLEN-1:0]              OUT_srcB         [NUM_UOPS],
  output logic [XLEN-1:0]              OUT_imm          [NUM_UOPS],
  output logic [$clog2(TAG_COUNT)-1:0] OUT_tagDst       [NUM_UOPS],
  output logic [4:0]                   OUT_nmDst        [NUM_UOPS],
  output logic [5:0]                   OUT_sqN          [NUM_UOPS],
  output logic [1:0]                   OUT_fu           [NUM_UOPS],
  output logic [5:0]                   OUT_opcode       [NUM_UOPS]
);

  localparam int         TAG_W  = $clog2(TAG_COUNT);
  localparam logic [1:0] FU_INT = 2'd0;

  typedef struct packed {
    logic             hold_valid;
    logic             pend_a;
    logic             pend_b;
    logic [TAG_W-1:0] tag_a;
    logic [TAG_W-1:0] tag_b;
    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  src_b;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag_dst;
    logic [4:0]       nm_dst;
    logic [5:0]       sqn;
    logic [1:0]       fu;
    logic [5:0]       opcode;
  } lane_t;

  lane_t           lane_q [NUM_UOPS];
  lane_t           lane_d [NUM_UOPS];
  logic [XLEN-1:0] regfile_q [TAG_COUNT];

  // Wrap-around age test: a is younger than b when the 6-bit difference is positive.
  function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] diff;
    diff = a - b;
    return !diff[5] && (diff != 6'd0);
  endfunction

  // NOTE: the register file is a plain memory with no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    // Descending order so the lowest bus index is the last write and wins on duplicate tags.
    for (int b = RESULT_BUS_COUNT - 1; b >= 0; b--) begin
      if (IN_resultValid[b]) regfile_q[IN_resultTag[b]] <= IN_resultData[b];
    end
  end

  logic            in_hit_a  [NUM_UOPS];
  logic            in_hit_b  [NUM_UOPS];
  logic            pd_hit_a  [NUM_UOPS];
  logic            pd_hit_b  [NUM_UOPS];
  logic [XLEN-1:0] in_data_a [NUM_UOPS];
  logic [XLEN-1:0] in_data_b [NUM_UOPS];
  logic [XLEN-1:0] pd_data_a [NUM_UOPS];
  logic [XLEN-1:0] pd_data_b [NUM_UOPS];
  logic            prod_a    [NUM_UOPS];
  logic            prod_b    [NUM_UOPS];

  always_comb begin
    for (int i = 0; i < NUM_UOPS; i++) begin
      in_hit_a[i]  = 1'b0;
      in_hit_b[i]  = 1'b0;
      pd_hit_a[i]  = 1'b0;
      pd_hit_b[i]  = 1'b0;
      in_data_a[i] = '0;
      in_data_b[i] = '0;
      pd_data_a[i] = '0;
      pd_data_b[i] = '0;
      prod_a[i]    = 1'b0;
      prod_b[i]    = 1'b0;
      for (int b = RESULT_BUS_COUNT - 1; b >= 0; b--) begin
        if (IN_resultValid[b] && IN_resultTag[b] == IN_tagA[i]) begin
          in_hit_a[i] = 1'b1; in_data_a[i] = IN_resultData[b];
        end
        if (IN_resultValid[b] && IN_resultTag[b] == IN_tagB[i]) begin
          in_hit_b[i] = 1'b1; in_data_b[i] = IN_resultData[b];
        end
        if (IN_resultValid[b] && IN_resultTag[b] == lane_q[i].tag_a) begin
          pd_hit_a[i] = 1'b1; pd_data_a[i] = IN_resultData[b];
        end
        if (IN_resultValid[b] && IN_resultTag[b] == lane_q[i].tag_b) begin
          pd_hit_b[i] = 1'b1; pd_data_b[i] = IN_resultData[b];
        end
      end
      // A held INT uop has woken its dependants early; its result is not in the file yet.
      for (int j = 0; j < NUM_UOPS; j++) begin
        if (lane_q[j].hold_valid && lane_q[j].fu == FU_INT) begin
          if (lane_q[j].tag_dst == IN_tagA[i]) prod_a[i] = 1'b1;
          if (lane_q[j].tag_dst == IN_tagB[i]) prod_b[i] = 1'b1;
        end
      end
    end
  end

  logic ready [NUM_UOPS];
  logic kill  [NUM_UOPS];

  always_comb begin
    for (int i = 0; i < NUM_UOPS; i++) begin
      lane_d[i] = lane_q[i];
      kill[i]   = lane_q[i].hold_valid && IN_invalidate && younger(lane_q[i].sqn, IN_invalidateSqN);
      ready[i]  = lane_q[i].hold_valid && (!lane_q[i].pend_a || pd_hit_a[i])
                                       && (!lane_q[i].pend_b || pd_hit_b[i]);

      OUT_valid[i]  = ready[i] && !kill[i];
      OUT_stall[i]  = lane_q[i].hold_valid && !(ready[i] && !IN_stall[i]);
      OUT_srcA[i]   = (lane_q[i].pend_a && pd_hit_a[i]) ? pd_data_a[i] : lane_q[i].src_a;
      OUT_srcB[i]   = (lane_q[i].pend_b && pd_hit_b[i]) ? pd_data_b[i] : lane_q[i].src_b;
      OUT_imm[i]    = lane_q[i].imm;
      OUT_tagDst[i] = lane_q[i].tag_dst;
      OUT_nmDst[i]  = lane_q[i].nm_dst;
      OUT_sqN[i]    = lane_q[i].sqn;
      OUT_fu[i]     = lane_q[i].fu;
      OUT_opcode[i] = lane_q[i].opcode;

      if (OUT_stall[i]) begin
        if (lane_q[i].pend_a && pd_hit_a[i]) begin
          lane_d[i].src_a  = pd_data_a[i];
          lane_d[i].pend_a = 1'b0;
        end
        if (lane_q[i].pend_b && pd_hit_b[i]) begin
          lane_d[i].src_b  = pd_data_b[i];
          lane_d[i].pend_b = 1'b0;
        end
        if (kill[i]) lane_d[i].hold_valid = 1'b0;
      end else begin
        lane_d[i].hold_valid = IN_uopValid[i] &&
                               !(IN_invalidate && younger(IN_sqN[i], IN_invalidateSqN));
        lane_d[i].tag_a   = IN_tagA[i];
        lane_d[i].tag_b   = IN_tagB[i];
        lane_d[i].imm     = IN_imm[i];
        lane_d[i].tag_dst = IN_tagDst[i];
        lane_d[i].nm_dst  = IN_nmDst[i];
        lane_d[i].sqn     = IN_sqN[i];
        lane_d[i].fu      = IN_fu[i];
        lane_d[i].opcode  = IN_opcode[i];

        lane_d[i].pend_a = 1'b0;
        if (in_hit_a[i])     lane_d[i].src_a = in_data_a[i];
        else if (prod_a[i])  lane_d[i].pend_a = 1'b1;
        else                 lane_d[i].src_a = regfile_q[IN_tagA[i]];

        lane_d[i].pend_b = 1'b0;
        if (IN_useImmB[i])   lane_d[i].src_b = IN_imm[i];
        else if (in_hit_b[i]) lane_d[i].src_b = in_data_b[i];
        else if (prod_b[i])  lane_d[i].pend_b = 1'b1;
        else                 lane_d[i].src_b = regfile_q[IN_tagB[i]];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every lane updates from the same snapshot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_UOPS; i++) begin
      if (rst) begin
        lane_q[i]            <= lane_d[i];
        lane_q[i].hold_valid <= 1'b0;
        lane_q[i].pend_a     <= 1'b0;
        lane_q[i].pend_b     <= 1'b0;
      end else begin
        lane_q[i] <= lane_d[i];
      end
    end
  end

endmodule
